dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive denied DMA-request cycles before DMA is forced ahead of the CPU.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port c_req  input  1  CPU MEM-stage access request.
REQ-005 SHALL have ports c_we (input, 1), c_addr (input, 32), c_wdata (input, 32), c_type (input, 3): CPU write enable, byte address, store data, and DMType encoding (word=000, half=001, half_u=010, byte=011, byte_u=100).
REQ-006 SHALL have port c_rdata  output  32  CPU load data.
REQ-007 SHALL have port c_stall  output  1  CPU must hold its request; asserted when c_req is high and the CPU is not granted this cycle.
REQ-008 SHALL have port d_req  input  1  DMA burst request.
REQ-009 SHALL have ports d_we (input, 1), d_addr (input, 32), d_len (input, 4), d_wdata (input, 32): DMA direction, word-aligned base address, beats minus one, and per-beat write data.
REQ-010 SHALL have ports d_ack (output, 1), d_rdata (output, 32), d_done (output, 1): beat accepted this cycle, beat read data, and a one-cycle pulse on the final beat.
REQ-011 SHALL have ports dm_wr (output, 1), dm_addr (output, 30, bits [31:2]), dm_din (output, 32), dm_type (output, 3), dm_dout (input, 32): data-memory side; reads are combinational and writes commit at posedge.

Function
REQ-012 SHALL implement two states: IDLE and BURST.
REQ-013 In IDLE, grant SHALL go to the CPU if c_req && !(d_req && starve==STARVE_MAX); otherwise it SHALL go to DMA if d_req.
REQ-014 A CPU grant SHALL drive dm_wr=c_we, dm_addr=c_addr[31:2], dm_din=c_wdata, dm_type=c_type, and c_rdata=dm_dout in the same cycle (zero added latency, c_stall=0).
REQ-015 A DMA grant in IDLE SHALL be beat 0: dm_addr=d_addr[31:2], dm_type=000, dm_wr=d_we, dm_din=d_wdata, d_ack=1, d_rdata=dm_dout.
REQ-016 On a DMA grant in IDLE, the block SHALL latch base=d_addr[31:2], last=d_len and beat=1; it SHALL then enter BURST if d_len!=0, or else stay in IDLE and pulse d_done.
REQ-017 In BURST, each cycle SHALL issue beat `beat` at dm_addr=base+beat (30-bit wrap-around, no carry out) with type word, d_ack=1, and beat incremented.
REQ-018 In BURST, d_req, d_addr and d_len SHALL be ignored; d_we SHALL be latched at grant.
REQ-019 When beat==last in BURST, d_done SHALL be 1 that cycle and the next state SHALL be IDLE.
REQ-020 A burst SHALL NOT be preempted; if c_req is high during BURST, c_stall=1.
REQ-021 The starve counter SHALL increment, saturating at STARVE_MAX, on each cycle d_req=1 and DMA is not granted.
REQ-022 The starve counter SHALL clear on any DMA grant, and on any cycle d_req=0.
REQ-023 When nothing is granted, outputs SHALL be dm_wr=0, dm_addr=0, dm_din=0, dm_type=000, d_ack=0, c_rdata=0, d_rdata=0.
REQ-024 dm_wr SHALL never be asserted for both requesters in one cycle; exactly one or zero grants per cycle.
REQ-025 Misaligned CPU addresses SHALL be passed through unchanged (bits [1:0] dropped); DMA d_addr[1:0] SHALL be ignored.

Reset
REQ-026 While rst=1, the state SHALL be IDLE and starve, beat, last, base and the latched d_we SHALL all be 0.
REQ-027 While rst=1, all outputs SHALL be driven as in REQ-023, with c_stall=0 and d_done=0.
REQ-028 Reset asserted mid-BURST SHALL abort the burst at the next posedge with no d_done; no further beats SHALL be issued.
REQ-029 The first cycle after rst deasserts SHALL arbitrate normally in IDLE.

Verification
REQ-030 CPU only: c_req=1, c_we=1, c_addr=0x10, c_wdata=0xDEADBEEF, c_type=000 -> dm_wr=1, dm_addr=0x4, c_stall=0; a next-cycle read returns 0xDEADBEEF.
REQ-031 DMA only: d_req=1, d_we=1, d_addr=0x100, d_len=3 -> d_ack for 4 consecutive cycles, dm_addr=0x40..0x43, d_done only in the 4th cycle, then IDLE.
REQ-032 Starvation: c_req and d_req held high with STARVE_MAX=4 -> CPU granted cycles 0-3, DMA granted cycle 4, c_stall=1 in cycle 4 and for the rest of the burst, starve reads 0 afterwards.
REQ-033 Single beat: d_len=0 with c_req=0 -> one d_ack with d_done in the same cycle, state stays IDLE.
REQ-034 Reset mid-burst: d_len=7, rst=1 at beat 3 -> next cycle dm_wr=0, d_ack=0, no d_done, IDLE.
REQ-035 Wrap: d_addr=0xFFFFFFF8, d_len=3 -> dm_addr sequence 0x3FFFFFFE, 0x3FFFFFFF, 0x00000000, 0x00000001.

Source files
------------

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU/DMA data-memory arbiter with word bursts and DMA anti-starvation
// The CPU wins by default; DMA is forced ahead after STARVE_MAX denied request cycles.
module dm_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_type,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_len,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        dm_wr,
  output logic [29:0] dm_addr,
  output logic [31:0] dm_din,
  output logic [2:0]  dm_type,
  input  logic [31:0] dm_dout
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]    state;
  logic [SW-1:0] starve;
  logic [3:0]    beat;
  logic [3:0]    last;
  logic [29:0]   base;
  logic          we_q;

  logic cpu_gnt;
  logic dma_first;
  logic dma_burst;

  // Byte-lane bits are dropped on both address paths.
  logic unused_ok;
  assign unused_ok = ^{c_addr[1:0], d_addr[1:0]};

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_first = 1'b0;
    dma_burst = 1'b0;
    if (!rst) begin
      if (state == S_BURST)
        dma_burst = 1'b1;
      else if (c_req && !(d_req && starve == SMAX))
        cpu_gnt = 1'b1;
      else if (d_req)
        dma_first = 1'b1;
    end
  end

  always_comb begin
    dm_wr   = 1'b0;
    dm_addr = 30'd0;
    dm_din  = 32'd0;
    dm_type = 3'b000;
    c_rdata = 32'd0;
    d_rdata = 32'd0;
    d_ack   = 1'b0;
    d_done  = 1'b0;
    c_stall = c_req && !cpu_gnt && !rst;
    if (cpu_gnt) begin
      dm_wr   = c_we;
      dm_addr = c_addr[31:2];
      dm_din  = c_wdata;
      dm_type = c_type;
      c_rdata = dm_dout;
    end else if (dma_first) begin
      dm_wr   = d_we;
      dm_addr = d_addr[31:2];
      dm_din  = d_wdata;
      d_ack   = 1'b1;
      d_rdata = dm_dout;
      d_done  = (d_len == 4'd0);
    end else if (dma_burst) begin
      dm_wr   = we_q;
      dm_addr = base + {26'd0, beat};
      dm_din  = d_wdata;
      d_ack   = 1'b1;
      d_rdata = dm_dout;
      d_done  = (beat == last);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      starve <= '0;
      beat   <= 4'd0;
      last   <= 4'd0;
      base   <= 30'd0;
      we_q   <= 1'b0;
    end else begin
      // Burst beats count as DMA grants, so the counter stays clear during a burst.
      if (dma_first || dma_burst || !d_req)
        starve <= '0;
      else if (starve != SMAX)
        starve <= starve + SW'(1);

      if (dma_first) begin
        base  <= d_addr[31:2];
        last  <= d_len;
        beat  <= 4'd1;
        we_q  <= d_we;
        state <= (d_len != 4'd0) ? S_BURST : S_IDLE;
      end else if (dma_burst) begin
        beat <= beat + 4'd1;
        if (beat == last)
          state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized and directed bench for dm_arbiter against a queue-based model
module tb_dm_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata;
  logic [2:0]  c_type;
  logic [31:0] c_rdata;
  logic        c_stall;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_len;
  logic        d_ack, d_done;
  logic [31:0] d_rdata;
  logic        dm_wr;
  logic [29:0] dm_addr;
  logic [31:0] dm_din;
  logic [2:0]  dm_type;
  logic [31:0] dm_dout;

  int checks = 0;
  int errors = 0;

  dm_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_type(c_type),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_done(d_done),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type), .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory, written by whatever the DUT issues.
  logic [31:0] mem [0:255];
  assign dm_dout = mem[dm_addr[7:0]];
  always @(posedge clk) if (dm_wr) mem[dm_addr[7:0]] <= dm_din;

  // Reference model: a queue of pending burst word addresses plus a starve count.
  logic [31:0] ref_mem [0:255];
  logic [29:0] bq[$];
  logic        bwe;
  int          starve_m;

  function automatic logic [132:0] obs();
    return {dm_wr, dm_addr, dm_din, dm_type, c_rdata, c_stall, d_ack, d_rdata, d_done};
  endfunction

  task automatic model_cycle(output logic [132:0] e);
    logic m_wr, m_stall, m_ack, m_done, cpu, dma;
    logic [29:0] m_addr;
    logic [31:0] m_din, m_crd, m_drd;
    logic [2:0]  m_type;
    m_wr = 0; m_stall = 0; m_ack = 0; m_done = 0; cpu = 0; dma = 0;
    m_addr = '0; m_din = '0; m_crd = '0; m_drd = '0; m_type = '0;
    if (rst) begin
      bq.delete();
      starve_m = 0;
    end else begin
      if (bq.size() > 0) begin
        dma = 1; m_addr = bq.pop_front(); m_wr = bwe; m_din = d_wdata;
        m_done = (bq.size() == 0);
      end else if (c_req && !(d_req && starve_m >= STARVE_MAX)) begin
        cpu = 1; m_addr = c_addr[31:2]; m_wr = c_we; m_din = c_wdata; m_type = c_type;
        m_crd = ref_mem[m_addr[7:0]];
      end else if (d_req) begin
        dma = 1; m_addr = d_addr[31:2]; m_wr = d_we; m_din = d_wdata; bwe = d_we;
        for (int i = 1; i <= int'(d_len); i++) bq.push_back(d_addr[31:2] + 30'(i));
        m_done = (d_len == 4'd0);
      end
      if (dma) begin m_ack = 1; m_drd = ref_mem[m_addr[7:0]]; end
      m_stall = c_req && !cpu;
      if (dma || !d_req) starve_m = 0;
      else if (starve_m < STARVE_MAX) starve_m++;
      if (m_wr) ref_mem[m_addr[7:0]] = m_din;
    end
    e = {m_wr, m_addr, m_din, m_type, m_crd, m_stall, m_ack, m_drd, m_done};
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_type = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_len = 0; d_wdata = 0;
  endtask

  task automatic test_reset();
    logic [132:0] e;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      c_req = 1; c_we = 1; c_addr = $urandom; c_wdata = $urandom; c_type = 3'($urandom_range(0, 4));
      d_req = 1; d_we = 1; d_addr = $urandom; d_len = 4'($urandom); d_wdata = $urandom;
      #2; model_cycle(e);
      checks++;
      if (obs() !== e || obs() !== 133'd0) begin
        errors++; $display("FAIL reset cyc=%0d got=%h want=%h", i, obs(), e);
      end
      advance();
    end
    rst = 0; idle_inputs();
  endtask

  task automatic test_cpu_only();
    logic [132:0] e;
    idle_inputs();
    c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF; c_type = 3'b000;
    #2; model_cycle(e);
    checks++;
    if (obs() !== e || dm_addr !== 30'h4 || dm_wr !== 1'b1 || c_stall !== 1'b0) begin
      errors++; $display("FAIL cpu_write got=%h want=%h", obs(), e);
    end
    advance();
    c_we = 0; c_wdata = 32'h0;
    #2; model_cycle(e);
    checks++;
    if (obs() !== e || c_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL cpu_read got=%h want=%h", obs(), e);
    end
    advance();
    c_we = 1; c_addr = 32'h13; c_wdata = 32'h000000A5; c_type = 3'b011;
    #2; model_cycle(e);
    checks++;
    if (obs() !== e || dm_addr !== 30'h4 || dm_type !== 3'b011) begin
      errors++; $display("FAIL cpu_misaligned got=%h want=%h", obs(), e);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_dma_only();
    logic [132:0] e;
    idle_inputs();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_len = 4'd3;
    for (int i = 0; i < 5; i++) begin
      d_wdata = $urandom;
      if (i == 4) d_req = 0;
      else if (i > 0) begin d_addr = $urandom; d_len = 4'($urandom); end
      #2; model_cycle(e);
      checks++;
      if (obs() !== e || d_ack !== (i < 4) || d_done !== (i == 3) ||
          (i < 4 && dm_addr !== 30'h40 + 30'(i))) begin
        errors++; $display("FAIL dma_only beat=%0d got=%h want=%h", i, obs(), e);
      end
      advance();
    end
    d_req = 1; d_we = 0; d_addr = 32'h102; d_len = 4'd1;
    for (int i = 0; i < 2; i++) begin
      #2; model_cycle(e);
      checks++;
      if (obs() !== e || dm_wr !== 1'b0) begin
        errors++; $display("FAIL dma_readback beat=%0d got=%h want=%h", i, obs(), e);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_starve();
    logic [132:0] e;
    idle_inputs();
    c_req = 1; d_req = 1; d_we = 0; d_addr = 32'h200; d_len = 4'd2;
    for (int i = 0; i < 14; i++) begin
      c_we = 0; c_addr = $urandom_range(0, 1023);
      #2; model_cycle(e);
      checks++;
      if (obs() !== e || d_ack !== ((i % 7) >= 4) || c_stall !== ((i % 7) >= 4)) begin
        errors++; $display("FAIL starve cyc=%0d got=%h want=%h", i, obs(), e);
      end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_single_beat();
    logic [132:0] e;
    idle_inputs();
    d_req = 1; d_we = 1; d_addr = 32'h3C; d_len = 4'd0; d_wdata = 32'h12345678;
    #2; model_cycle(e);
    checks++;
    if (obs() !== e || d_ack !== 1'b1 || d_done !== 1'b1 || dm_addr !== 30'hF) begin
      errors++; $display("FAIL single_beat got=%h want=%h", obs(), e);
    end
    advance();
    idle_inputs();
    c_req = 1; c_addr = 32'h3C;
    #2; model_cycle(e);
    checks++;
    if (obs() !== e || c_stall !== 1'b0 || c_rdata !== 32'h12345678) begin
      errors++; $display("FAIL single_beat_idle got=%h want=%h", obs(), e);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    logic [132:0] e;
    idle_inputs();
    d_req = 1; d_we = 1; d_addr = 32'h80; d_len = 4'd7;
    for (int i = 0; i < 6; i++) begin
      d_wdata = $urandom;
      rst = (i == 3);
      if (i == 4) begin d_req = 0; c_req = 1; c_addr = 32'h84; end
      if (i == 5) begin c_req = 0; d_req = 1; d_addr = 32'h300; d_len = 4'd0; end
      #2; model_cycle(e);
      checks++;
      if (obs() !== e || (i == 3 && (dm_wr !== 1'b0 || d_ack !== 1'b0 || d_done !== 1'b0)) ||
          (i == 4 && (d_ack !== 1'b0 || c_stall !== 1'b0)) || (i == 5 && dm_addr !== 30'hC0)) begin
        errors++; $display("FAIL reset_mid_burst cyc=%0d got=%h want=%h", i, obs(), e);
      end
      advance();
    end
    rst = 0; idle_inputs();
  endtask

  task automatic test_wrap();
    logic [132:0] e;
    logic [29:0] want [0:3];
    want[0] = 30'h3FFFFFFE; want[1] = 30'h3FFFFFFF; want[2] = 30'h0; want[3] = 30'h1;
    idle_inputs();
    d_req = 1; d_we = 0; d_addr = 32'hFFFFFFF8; d_len = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #2; model_cycle(e);
      checks++;
      if (obs() !== e || dm_addr !== want[i] || d_done !== (i == 3)) begin
        errors++; $display("FAIL wrap beat=%0d got=%h want=%h", i, obs(), e);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [132:0] e;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      c_req = ($urandom_range(0, 9) < 6); c_we = 1'($urandom);
      c_addr = $urandom; c_wdata = $urandom; c_type = 3'($urandom_range(0, 4));
      d_req = ($urandom_range(0, 9) < 4); d_we = 1'($urandom);
      d_addr = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFF0 | 32'($urandom_range(0, 15)) : $urandom;
      d_len = 4'($urandom_range(0, 5)); d_wdata = $urandom;
      #2; model_cycle(e);
      checks++;
      if (obs() !== e || (dm_wr && d_ack && c_req && !c_stall)) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs(), e);
      end
      advance();
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    bwe = 0; starve_m = 0;
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_cpu_only();
    test_dma_only();
    test_starve();
    test_single_beat();
    test_reset_mid_burst();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
